// File: rtl/fortune_spinner.sv
// Fortune spinner: a held button spins a 0..9 digit, which then decelerates and is
// latched with two category switches into a 6-bit pattern with a one-cycle valid strobe.
module fortune_spinner #(
    parameter int TICK_DIV     = 4,
    parameter int SETTLE_STEPS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       sel_a,
    input  logic       sel_b,
    output logic [5:0] pattern,
    output logic       pattern_valid,
    output logic [3:0] digit_live,
    output logic       busy
);

    // The prescaler must reach 2*TICK_DIV-1 (settle rate); steps_left must hold SETTLE_STEPS.
    localparam int PRE_W  = (2 * TICK_DIV > 1) ? $clog2(2 * TICK_DIV) : 1;
    localparam int STEP_W = (SETTLE_STEPS > 0) ? $clog2(SETTLE_STEPS + 1) : 1;

    localparam logic [PRE_W-1:0]  SPIN_TC    = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  SETTLE_TC  = PRE_W'(2 * TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEPS_INIT = STEP_W'(SETTLE_STEPS);
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
    localparam bit                NO_SETTLE  = (SETTLE_STEPS == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPIN,
        ST_SETTLE,
        ST_CAPTURE
    } state_e;

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [3:0]        digit_q, digit_d;
    logic [5:0]        pattern_q, pattern_d;
    logic              valid_q, valid_d;

    logic btn_meta_q;
    logic btn_s_q;
    logic btn_s_dly_q;
    logic btn_rise;

    function automatic logic [3:0] step_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // NOTE: sequential state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            btn_s_dly_q <= 1'b0;
        end else begin
            btn_meta_q  <= btn;
            btn_s_q     <= btn_meta_q;
            btn_s_dly_q <= btn_s_q;
        end
    end

    assign btn_rise = btn_s_q & ~btn_s_dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            steps_q   <= '0;
            digit_q   <= 4'd0;
            pattern_q <= 6'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            steps_q   <= steps_d;
            digit_q   <= digit_d;
            pattern_q <= pattern_d;
            valid_q   <= valid_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        steps_d   = steps_q;
        digit_d   = digit_q;
        pattern_d = pattern_q;
        valid_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The digit is deliberately kept so a new spin resumes where the last stopped.
                if (btn_rise) begin
                    state_d = ST_SPIN;
                    presc_d = '0;
                end
            end

            ST_SPIN: begin
                if (presc_q == SPIN_TC) begin
                    presc_d = '0;
                    digit_d = step_digit(digit_q);
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
                // Release overrides the prescaler but keeps a coincident terminal-count step.
                if (!btn_s_q) begin
                    presc_d = '0;
                    if (NO_SETTLE) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_SETTLE;
                        steps_d = STEPS_INIT;
                    end
                end
            end

            ST_SETTLE: begin
                if (presc_q == SETTLE_TC) begin
                    presc_d = '0;
                    digit_d = step_digit(digit_q);
                    steps_d = steps_q - STEP_ONE;
                    if (steps_q == STEP_ONE) begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end

            ST_CAPTURE: begin
                pattern_d = {sel_b, digit_q, sel_a};
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pattern       = pattern_q;
    assign pattern_valid = valid_q;
    assign digit_live    = digit_q;
    assign busy          = (state_q != ST_IDLE);

    digit_range_a: assert property (@(posedge clk) disable iff (reset) (digit_q <= 4'd9));

endmodule

// File: tb/tb_fortune_spinner.sv
// Directed bench for fortune_spinner: a default instance (TICK_DIV=4, SETTLE_STEPS=3)
// and a SETTLE_STEPS=0 instance, with hand-computed patterns and latencies.
module tb_fortune_spinner;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic       btn;
    logic       btn0;
    logic       sel_a;
    logic       sel_b;

    logic [5:0] pattern;
    logic       pattern_valid;
    logic [3:0] digit_live;
    logic       busy;

    logic [5:0] pattern0;
    logic       pattern_valid0;
    logic [3:0] digit_live0;
    logic       busy0;

    int n_checks;
    int n_fail;
    int valid_cnt;
    int valid0_cnt;
    int busy_cnt;
    int range_viol;
    int edges;

    fortune_spinner #(.TICK_DIV(4), .SETTLE_STEPS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .pattern      (pattern),
        .pattern_valid(pattern_valid),
        .digit_live   (digit_live),
        .busy         (busy)
    );

    fortune_spinner #(.TICK_DIV(4), .SETTLE_STEPS(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn0),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .pattern      (pattern0),
        .pattern_valid(pattern_valid0),
        .digit_live   (digit_live0),
        .busy         (busy0)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    always @(negedge clk) begin
        if (pattern_valid)  valid_cnt++;
        if (pattern_valid0) valid0_cnt++;
        if (busy)           busy_cnt++;
        if (!reset && (digit_live > 4'd9 || pattern[4:1] > 4'd9 ||
                       digit_live0 > 4'd9 || pattern0[4:1] > 4'd9)) range_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the selected button for n clock periods, starting and ending on a falling edge.
    task automatic hold(input bit which0, input int n);
        if (which0) btn0 = 1'b1; else btn = 1'b1;
        cyc(n);
        if (which0) btn0 = 1'b0; else btn = 1'b0;
    endtask

    // Counts rising edges until the valid strobe is seen; -1 if the budget runs out.
    task automatic wait_valid(input bit which0, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (which0 ? pattern_valid0 : pattern_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        valid_cnt  = 0;
        valid0_cnt = 0;
        busy_cnt   = 0;
        range_viol = 0;
        clk_en     = 1'b1;
        reset      = 1'b1;
        btn        = 1'b0;
        btn0       = 1'b0;
        sel_a      = 1'b0;
        sel_b      = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        check("rst_pattern", 32'(pattern), 32'd0);
        check("rst_valid", 32'(pattern_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_digit", 32'(digit_live), 32'd0);

        // 1: reset mid-spin with the clock stopped must clear outputs immediately.
        btn = 1'b1;
        cyc(10);
        check("t1_busy_pre", 32'(busy), 32'd1);
        check("t1_digit_pre", 32'(digit_live), 32'd1);
        clk_en = 1'b0;
        #20;
        reset = 1'b1;
        #1;
        check("t1_pattern", 32'(pattern), 32'd0);
        check("t1_valid", 32'(pattern_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_digit", 32'(digit_live), 32'd0);
        btn    = 1'b0;
        clk_en = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(3);

        // 2: 8-cycle spin from 0 -> 2, settle 3 -> 5; release-to-valid = 3 + 24 + 1.
        sel_a     = 1'b1;
        sel_b     = 1'b0;
        valid_cnt = 0;
        busy_cnt  = 0;
        hold(1'b0, 8);
        wait_valid(1'b0, edges);
        check("t2_latency", 32'(edges), 32'd28);
        check("t2_pattern", 32'(pattern), 32'(6'b001011));
        check("t2_digit", 32'(digit_live), 32'd5);
        cyc(5);
        check("t2_one_valid", 32'(valid_cnt), 32'd1);
        check("t2_busy_cycles", 32'(busy_cnt), 32'd33);

        // Short spin with no step: 5 settles to 8.
        sel_a = 1'b0;
        sel_b = 1'b0;
        hold(1'b0, 2);
        wait_valid(1'b0, edges);
        check("prep_latency", 32'(edges), 32'd28);
        check("prep_pattern", 32'(pattern), 32'(6'b010000));
        cyc(3);

        // 3: wrap 8 -> 9 -> 0 -> 1 while spinning, settle to 4.
        sel_a = 1'b1;
        sel_b = 1'b1;
        hold(1'b0, 12);
        wait_valid(1'b0, edges);
        check("t3_latency", 32'(edges), 32'd28);
        check("t3_pattern", 32'(pattern), 32'(6'b101001));
        check("t3_digit", 32'(digit_live), 32'd4);
        cyc(3);

        // 4: reset in SETTLE aborts with no strobe.
        hold(1'b0, 4);
        cyc(10);
        check("t4_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        cyc(2);
        check("t4_pattern_rst", 32'(pattern), 32'd0);
        check("t4_busy_rst", 32'(busy), 32'd0);
        reset     = 1'b0;
        valid_cnt = 0;
        cyc(60);
        check("t4_no_valid", 32'(valid_cnt), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_pattern", 32'(pattern), 32'd0);
        check("t4_digit", 32'(digit_live), 32'd0);

        // 5: re-press during SETTLE is ignored; spin 0 -> 1, settle to 4.
        sel_a     = 1'b0;
        sel_b     = 1'b1;
        valid_cnt = 0;
        hold(1'b0, 4);
        cyc(8);
        hold(1'b0, 4);
        wait_valid(1'b0, edges);
        check("t5_latency", 32'(edges), 32'd16);
        check("t5_pattern", 32'(pattern), 32'(6'b101000));
        busy_cnt = 0;
        cyc(40);
        check("t5_one_valid", 32'(valid_cnt), 32'd1);
        check("t5_no_restart", 32'(busy_cnt), 32'd0);
        check("t5_digit", 32'(digit_live), 32'd4);

        // 6: SETTLE_STEPS=0 captures right after SPIN sees the release.
        sel_a      = 1'b1;
        sel_b      = 1'b0;
        valid0_cnt = 0;
        hold(1'b1, 6);
        wait_valid(1'b1, edges);
        check("t6_latency", 32'(edges), 32'd4);
        check("t6_pattern", 32'(pattern0), 32'(6'b000011));
        cyc(4);
        check("t6_digit", 32'(digit_live0), 32'd1);
        sel_a = 1'b0;
        hold(1'b1, 4);
        wait_valid(1'b1, edges);
        check("t6_tc_latency", 32'(edges), 32'd4);
        check("t6_tc_pattern", 32'(pattern0), 32'(6'b000100));
        cyc(4);
        check("t6_valid_count", 32'(valid0_cnt), 32'd2);
        check("t6_idle", 32'(busy0), 32'd0);

        check("digit_range", 32'(range_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
